note_seq_ctrl: RTL and testbench

NOTE_SEQ_CTRL -- requirements
Module: note_seq_ctrl

---
 rtl/note_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_note_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/note_seq_ctrl.sv
// note_seq_ctrl: records a sequence of note codes from button pulses and
// plays them back in a loop. Each note is held for BEAT_LEN clock cycles.
module note_seq_ctrl #(
   parameter int DEPTH    = 16,
   parameter int NOTE_W   = 4,
   parameter int BEAT_LEN = 12500000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              button_pulse,
   input  logic [NOTE_W-1:0]       note_sel,
   output logic [NOTE_W-1:0]       note_out,
   output logic                    note_valid,
   output logic [1:0]              mode,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full
);

   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int BEAT_W = $clog2(BEAT_LEN);

   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_LEN - 1);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_REC  = 2'b01;
   localparam logic [1:0] S_PLAY = 2'b10;

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_count;
   logic              r_full;
   logic [NOTE_W-1:0] r_note;
   logic              r_valid;
   logic [IDX_W-1:0]  r_idx;
   logic [BEAT_W-1:0] r_beat;
   logic [NOTE_W-1:0] r_mem [DEPTH];

   logic              w_rec;
   logic              w_play;
   logic              w_enter;
   logic              w_clr;
   logic              w_wr_en;
   logic              w_last_idx;
   logic              w_beat_end;
   logic [IDX_W-1:0]  w_next_idx;

   // Saturating increment: the note count never wraps past DEPTH.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v >= DEPTH_C) ? v : v + CNT_W'(1);
   endfunction

   assign w_rec   = button_pulse[0];
   assign w_play  = button_pulse[1];
   assign w_enter = button_pulse[2];
   assign w_clr   = button_pulse[3];

   // Enter only writes in REC when no higher-priority pulse acts and space remains.
   assign w_wr_en = !reset && !w_clr && !w_rec && w_enter && !r_full && (r_state == S_REC);

   assign w_beat_end = (r_beat == BEAT_LAST);
   assign w_last_idx = ({1'b0, r_idx} == (r_count - CNT_W'(1)));
   assign w_next_idx = w_last_idx ? '0 : r_idx + IDX_W'(1);

   // Note memory: synchronous write at the current fill position, never reset.
   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_mem[r_count[IDX_W-1:0]] <= note_sel;
   end

   // Mode FSM, note counting and playback sequencing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_full  <= 1'b0;
         r_note  <= '0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_beat  <= '0;
      end else if (w_clr) begin
         // Clear drops all notes; note_out keeps its last value.
         r_state <= S_IDLE;
         r_count <= '0;
         r_full  <= 1'b0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_beat  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_rec) begin
                  r_state <= S_REC;
               end else if (w_play && (r_count != '0)) begin
                  r_state <= S_PLAY;
                  r_idx   <= '0;
                  r_beat  <= '0;
                  r_note  <= r_mem[0];
                  r_valid <= 1'b1;
               end
            end
            S_REC: begin
               if (w_rec) begin
                  r_state <= S_IDLE;
               end else if (w_enter && !r_full) begin
                  r_count <= sat_inc(r_count);
                  r_full  <= (sat_inc(r_count) == DEPTH_C);
               end
            end
            S_PLAY: begin
               if (w_play) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
               end else if (w_beat_end) begin
                  // Next note is loaded on the same edge the index advances.
                  r_beat <= '0;
                  r_idx  <= w_next_idx;
                  r_note <= r_mem[w_next_idx];
               end else begin
                  r_beat <= r_beat + BEAT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign mode       = r_state;
   assign count      = r_count;
   assign full       = r_full;
   assign note_out   = r_note;
   assign note_valid = r_valid;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// tb_note_seq_ctrl: directed scenarios followed by random pulses, all checked
// against a queue-based reference model of the note sequencer.
module tb_note_seq_ctrl;

   localparam int DEPTH    = 4;
   localparam int NOTE_W   = 4;
   localparam int BEAT_LEN = 4;

   localparam logic [3:0] P_NONE  = 4'b0000;
   localparam logic [3:0] P_REC   = 4'b0001;
   localparam logic [3:0] P_PLAY  = 4'b0010;
   localparam logic [3:0] P_ENTER = 4'b0100;
   localparam logic [3:0] P_CLR   = 4'b1000;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [3:0]        button_pulse = '0;
   logic [NOTE_W-1:0] note_sel = '0;
   logic [NOTE_W-1:0] note_out;
   logic              note_valid;
   logic [1:0]        mode;
   logic [2:0]        count;
   logic              full;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: mode, list of stored notes, cycles since play start.
   int          m_mode = 0;
   int          m_q[$];
   int          m_t = 0;
   logic [3:0]  m_note = '0;
   logic        m_valid = 1'b0;

   note_seq_ctrl #(.DEPTH(DEPTH), .NOTE_W(NOTE_W), .BEAT_LEN(BEAT_LEN)) dut (
      .clk          (clk),
      .reset        (reset),
      .button_pulse (button_pulse),
      .note_sel     (note_sel),
      .note_out     (note_out),
      .note_valid   (note_valid),
      .mode         (mode),
      .count        (count),
      .full         (full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Behavioural model of one clock edge; note played = position in time / beat length.
   task automatic model_edge(input logic rst, input logic [3:0] p, input logic [3:0] ns);
      if (rst) begin
         m_mode = 0; m_q.delete(); m_note = '0; m_valid = 1'b0; m_t = 0;
      end else if (p[3]) begin
         m_mode = 0; m_q.delete(); m_valid = 1'b0;
      end else begin
         case (m_mode)
            0: begin
               if (p[0]) m_mode = 1;
               else if (p[1] && m_q.size() > 0) begin
                  m_mode = 2; m_t = 0; m_note = 4'(m_q[0]); m_valid = 1'b1;
               end
            end
            1: begin
               if (p[0]) m_mode = 0;
               else if (p[2] && m_q.size() < DEPTH) m_q.push_back(int'(ns));
            end
            default: begin
               if (p[1]) begin
                  m_mode = 0; m_valid = 1'b0;
               end else begin
                  m_t++;
                  m_note = 4'(m_q[(m_t / BEAT_LEN) % m_q.size()]);
               end
            end
         endcase
      end
   endtask

   // Apply one cycle of inputs, advance the model, then compare all outputs.
   task automatic tick(input logic rst, input logic [3:0] p, input logic [3:0] ns);
      reset = rst;
      button_pulse = p;
      note_sel = ns;
      @(posedge clk);
      model_edge(rst, p, ns);
      #1;
      reset = 1'b0;
      button_pulse = P_NONE;
      chk("mode",       32'(mode),       32'(m_mode));
      chk("count",      32'(count),      32'(m_q.size()));
      chk("full",       32'(full),       32'(m_q.size() == DEPTH));
      chk("note_valid", 32'(note_valid), 32'(m_valid));
      chk("note_out",   32'(note_out),   32'(m_note));
   endtask

   initial begin
      int exp33[13] = '{3, 3, 3, 3, 7, 7, 7, 7, 9, 9, 9, 9, 3};
      int r;
      logic [3:0] p;

      // Reset state
      tick(1'b1, P_NONE, 4'd0);
      tick(1'b1, P_NONE, 4'd0);
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_note", 32'(note_out), 32'd0);
      chk("rst_valid", 32'(note_valid), 32'd0);

      // Record flow: 3, 7, 9
      tick(1'b0, P_REC, 4'd0);
      tick(1'b0, P_ENTER, 4'd3);
      tick(1'b0, P_ENTER, 4'd7);
      tick(1'b0, P_ENTER, 4'd9);
      chk("rec_mode", 32'(mode), 32'd1);
      chk("rec_count", 32'(count), 32'd3);
      chk("rec_full", 32'(full), 32'd0);

      // Playback with 1-cycle latency, 4-cycle hold, looping
      tick(1'b0, P_REC, 4'd0);
      tick(1'b0, P_PLAY, 4'd0);
      chk("play_valid", 32'(note_valid), 32'd1);
      chk("play_seq0", 32'(note_out), 32'(exp33[0]));
      for (int k = 1; k < 13; k++) begin
         tick(1'b0, P_NONE, 4'd0);
         chk("play_seq", 32'(note_out), 32'(exp33[k]));
      end

      // Stop mid-note (second note), then restart from mem[0]
      for (int k = 0; k < 5; k++) tick(1'b0, P_NONE, 4'd0);
      chk("pre_stop_note", 32'(note_out), 32'd7);
      tick(1'b0, P_PLAY, 4'd0);
      chk("stop_mode", 32'(mode), 32'd0);
      chk("stop_valid", 32'(note_valid), 32'd0);
      chk("stop_hold", 32'(note_out), 32'd7);
      tick(1'b0, P_PLAY, 4'd0);
      chk("restart_note", 32'(note_out), 32'd3);
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, P_NONE, 4'd0);
         chk("restart_hold", 32'(note_out), 32'd3);
      end
      tick(1'b0, P_NONE, 4'd0);
      chk("restart_next", 32'(note_out), 32'd7);

      // Reset during the second note
      tick(1'b1, P_NONE, 4'd0);
      chk("rstplay_mode", 32'(mode), 32'd0);
      chk("rstplay_valid", 32'(note_valid), 32'd0);
      chk("rstplay_note", 32'(note_out), 32'd0);
      chk("rstplay_count", 32'(count), 32'd0);

      // Full memory: fifth write is dropped
      tick(1'b0, P_REC, 4'd0);
      for (int i = 1; i <= 5; i++) tick(1'b0, P_ENTER, 4'(i));
      chk("full_count", 32'(count), 32'd4);
      chk("full_flag", 32'(full), 32'd1);
      tick(1'b0, P_REC, 4'd0);
      tick(1'b0, P_PLAY, 4'd0);
      chk("full_seq0", 32'(note_out), 32'd1);
      for (int k = 1; k < 17; k++) begin
         tick(1'b0, P_NONE, 4'd0);
         chk("full_seq", 32'(note_out), 32'(((k / 4) % 4) + 1));
      end
      tick(1'b0, P_PLAY, 4'd0);

      // Priority: clear beats record in REC; play with no notes is ignored
      tick(1'b0, P_REC, 4'd0);
      tick(1'b0, P_CLR | P_REC, 4'd0);
      chk("prio_mode", 32'(mode), 32'd0);
      chk("prio_count", 32'(count), 32'd0);
      tick(1'b0, P_PLAY, 4'd0);
      chk("empty_play_mode", 32'(mode), 32'd0);
      chk("empty_play_valid", 32'(note_valid), 32'd0);
      tick(1'b0, P_REC | P_PLAY, 4'd0);
      chk("rec_over_play", 32'(mode), 32'd1);
      tick(1'b0, P_REC, 4'd0);

      // Random single-pulse traffic against the model
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 99);
         if (r < 2)       p = P_NONE;
         else if (r < 5)  p = P_CLR;
         else if (r < 13) p = P_REC;
         else if (r < 20) p = P_PLAY;
         else if (r < 55) p = P_ENTER;
         else             p = P_NONE;
         tick(r < 2, p, 4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
